// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and the fixed iteration count.
package mdu_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam int ITERATIONS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply and restoring
// divide on magnitudes, 32 iterations, sign fix-up applied when HI/LO are written.
//
// state | meaning
// IDLE  | accepts start, or mthi/mtlo moves into HI/LO
// RUN   | one iteration per cycle; final edge writes fixed-up result to HI/LO
// DONE  | single-cycle done pulse, then back to IDLE
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] operandA,
  input  logic [DATA_W-1:0] operandB,
  input  logic              mthi,
  input  logic              mtlo,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam logic [5:0] ITER_CNT = 6'(ITERATIONS);

  state_t              state;
  logic [5:0]          cnt;
  logic                is_div_q;
  logic                neg_res;
  logic                neg_rem;
  logic                div_zero;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   m_q;
  logic [2*DATA_W-1:0] acc;

  logic                signed_op;
  logic                is_div;
  logic                a_neg;
  logic                b_neg;
  logic [DATA_W-1:0]   a_mag;
  logic [DATA_W-1:0]   b_mag;

  logic [DATA_W:0]     sum;
  logic [DATA_W:0]     shifted;
  logic [DATA_W:0]     diff;
  logic [2*DATA_W-1:0] acc_step;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   q_fix;
  logic [DATA_W-1:0]   r_fix;
  logic [DATA_W-1:0]   res_hi;
  logic [DATA_W-1:0]   res_lo;

  always_comb begin
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    is_div    = (op == OP_DIV) || (op == OP_DIVU);
    a_neg     = signed_op & operandA[DATA_W-1];
    b_neg     = signed_op & operandB[DATA_W-1];
    a_mag     = a_neg ? -operandA : operandA;
    b_mag     = b_neg ? -operandB : operandB;
  end

  // acc holds {partial product | multiplier} or {remainder | dividend/quotient}
  always_comb begin
    sum     = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, m_q};
    shifted = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
    diff    = shifted - {1'b0, m_q};

    if (is_div_q) begin
      acc_step = diff[DATA_W] ? {shifted[DATA_W-1:0], acc[DATA_W-2:0], 1'b0}
                              : {diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
    end else begin
      acc_step = acc[0] ? {sum, acc[DATA_W-1:1]} : {1'b0, acc[2*DATA_W-1:1]};
    end

    prod_fix = neg_res ? -acc : acc;
    q_fix    = neg_res ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
    r_fix    = neg_rem ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];

    res_hi = prod_fix[2*DATA_W-1:DATA_W];
    res_lo = prod_fix[DATA_W-1:0];
    if (is_div_q) begin
      // Divide by zero bypasses the sign fix-up: quotient all ones, HI = raw dividend
      if (div_zero) begin
        res_hi = a_q;
        res_lo = '1;
      end else begin
        res_hi = r_fix;
        res_lo = q_fix;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      is_div_q <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      a_q      <= '0;
      m_q      <= '0;
      acc      <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            is_div_q <= is_div;
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            div_zero <= (operandB == '0);
            a_q      <= operandA;
            m_q      <= is_div ? b_mag : a_mag;
            acc      <= {{DATA_W{1'b0}}, (is_div ? a_mag : b_mag)};
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= RUN;
          end else begin
            if (mthi) hi <= operandA;
            if (mtlo) lo <= operandA;
          end
        end
        RUN: begin
          if (cnt == ITER_CNT) begin
            hi    <= res_hi;
            lo    <= res_lo;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            acc <= acc_step;
            cnt <= cnt + 6'd1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table of operations with
// hand-computed HI/LO, plus move, ignore-while-busy and mid-run reset sequences.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] operandA = '0;
  logic [31:0] operandB = '0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
    string       nm;
  } vec_t;

  vec_t vecs[$];

  mult_div_unit #(.DATA_W(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .operandA (operandA),
    .operandB (operandB),
    .mthi     (mthi),
    .mtlo     (mtlo),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic move(input bit h, input bit l, input logic [31:0] v);
    @(negedge clock);
    mthi = h; mtlo = l; operandA = v;
    @(posedge clock); #1;
    mthi = 1'b0; mtlo = 1'b0;
    if (h) hi_m = v;
    if (l) lo_m = v;
    chk("move_hi", hi, hi_m);
    chk("move_lo", lo, lo_m);
  endtask

  // mode 0: plain; 1: start+mthi+mtlo poked at iteration 5; 2: mtlo alongside start in IDLE
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input string nm, input int mode);
    @(negedge clock);
    start = 1'b1; op = o; operandA = a; operandB = b;
    if (mode == 2) mtlo = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; mtlo = 1'b0;
    for (int i = 0; i <= 32; i++) begin
      if (i > 0) begin
        if (mode == 1 && i == 5) begin
          start = 1'b1; mthi = 1'b1; mtlo = 1'b1; operandA = 32'hDEADBEEF;
        end
        @(posedge clock); #1;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      end
      chk({nm, "_busy_run"}, busy, 1'b1);
      chk({nm, "_done_run"}, done, 1'b0);
      chk({nm, "_hi_hold"}, hi, hi_m);
      chk({nm, "_lo_hold"}, lo, lo_m);
    end
    @(posedge clock); #1;
    hi_m = ehi; lo_m = elo;
    chk({nm, "_done"}, done, 1'b1);
    chk({nm, "_busy_end"}, busy, 1'b0);
    chk({nm, "_hi"}, hi, ehi);
    chk({nm, "_lo"}, lo, elo);
    @(posedge clock); #1;
    chk({nm, "_done_clear"}, done, 1'b0);
    chk({nm, "_busy_idle"}, busy, 1'b0);
  endtask

  initial begin
    vecs.push_back('{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max"});
    vecs.push_back('{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, "mult_neg3x5"});
    vecs.push_back('{OP_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, "divu_100_7"});
    vecs.push_back('{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg7_2"});
    vecs.push_back('{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_ovf"});
    vecs.push_back('{OP_DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, "divu_zero"});
    vecs.push_back('{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, "div_zero"});
    vecs.push_back('{OP_MULT,  32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2, "mult_7xneg2"});
    vecs.push_back('{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_7_neg2"});
    vecs.push_back('{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, "multu_shift"});
    vecs.push_back('{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, "mult_neg1sq"});
    vecs.push_back('{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, "divu_big"});

    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    @(negedge clock);
    reset = 1'b0;

    move(1'b1, 1'b0, 32'h12345678);
    move(1'b1, 1'b1, 32'hCAFEF00D);

    for (int i = 0; i < vecs.size(); i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo, vecs[i].nm, 0);

    run_op(OP_MULTU, 32'h3, 32'h4, 32'h0, 32'hC, "poke_run", 1);
    move(1'b1, 1'b1, 32'h0BADF00D);
    run_op(OP_MULTU, 32'h5, 32'h6, 32'h0, 32'h1E, "start_mtlo", 2);

    // reset in the middle of an operation
    move(1'b1, 1'b1, 32'hA5A5A5A5);
    @(negedge clock);
    start = 1'b1; op = OP_DIVU; operandA = 32'h64; operandB = 32'h7;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    hi_m = '0; lo_m = '0;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_hi", hi, 32'h0);
    chk("midrst_lo", lo, 32'h0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      chk("post_rst_no_done", done, 1'b0);
      chk("post_rst_idle", busy, 1'b0);
    end
    run_op(OP_MULTU, 32'h6, 32'h7, 32'h0, 32'h2A, "after_rst", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
